// File: rtl/decim_pkg.sv
// decim_pkg: shared types and helpers for the decimation controller.
//   state_t   - controller FSM encoding (IDLE, FLUSH, DRAIN, RUN)
//   flush_len - zero-injection cycles needed to clear stages 1..k
//   drain_len - settling cycles after the flush for an n-stage cascade
//   SAMPLE_W  - audio sample width
package decim_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    // 28 zeros per stage-1 delay line, doubled for every stage further down
    function automatic logic [CNT_W-1:0] flush_len(input int unsigned k);
        return CNT_W'(28 * ((32'd1 << k) - 32'd1));
    endfunction

    function automatic logic [CNT_W-1:0] drain_len(input int unsigned n);
        return CNT_W'(5 * n);
    endfunction

endpackage

// File: rtl/decim_fifo.sv
// decim_fifo: registered output FIFO (no fall-through).
//   clr        - synchronous clear, wins over push/pop
//   push/din   - write; caller only pushes when not full or popping
//   pop        - advance head; caller only pops when not empty
//   head       - current oldest entry
//   full/empty - occupancy flags
module decim_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            // push into a full FIFO is legal alongside a pop: wr_q == rd_q,
            // and the slot being overwritten is the one leaving this cycle
            if (push) begin
                mem_d[wr_q] = din;
                wr_d        = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (AW+1)'(1);
                2'b01:   cnt_d = cnt_q - (AW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/hb.sv
// hb: halfband decimate-by-2 filter stage.
//   Taps (-1, 0, 9, 16, 9, 0, -1)/32, unity DC gain, saturating output.
//   x_in/x_in_valid  - input sample and strobe (registered once: one-sample skew)
//   y_out/y_out_valid - one output pulse for every second accepted input
module hb (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] x_in,
    input  logic        x_in_valid,
    output logic [15:0] y_out,
    output logic        y_out_valid
);

    logic signed [15:0] x_q, x_d;
    logic               xv_q, xv_d;
    logic signed [15:0] d_q [6];
    logic signed [15:0] d_d [6];
    logic               phase_q, phase_d;
    logic        [15:0] y_q, y_d;
    logic               yv_q, yv_d;
    logic signed [23:0] acc;
    logic signed [23:0] rnd;

    function automatic logic signed [23:0] sx(input logic signed [15:0] v);
        return {{8{v[15]}}, v};
    endfunction

    always_comb begin
        // x_q is tap 0, d_q[i] is tap i+1
        acc = sx(d_q[1]) * 24'sd9 + sx(d_q[2]) * 24'sd16 + sx(d_q[3]) * 24'sd9
              - sx(x_q) - sx(d_q[5]);
        rnd = (acc + 24'sd16) >>> 5;

        x_d     = $signed(x_in);
        xv_d    = x_in_valid;
        d_d     = d_q;
        phase_d = phase_q;
        y_d     = y_q;
        yv_d    = 1'b0;

        if (xv_q) begin
            d_d[0] = x_q;
            for (int unsigned i = 1; i < 6; i++) begin
                d_d[i] = d_q[i-1];
            end
            phase_d = ~phase_q;
            if (phase_q) begin
                yv_d = 1'b1;
                if (rnd > 24'sd32767) begin
                    y_d = 16'h7fff;
                end else if (rnd < -24'sd32768) begin
                    y_d = 16'h8000;
                end else begin
                    y_d = rnd[15:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_q     <= '0;
            xv_q    <= 1'b0;
            d_q     <= '{default: '0};
            phase_q <= 1'b0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            x_q     <= x_d;
            xv_q    <= xv_d;
            d_q     <= d_d;
            phase_q <= phase_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign y_out       = y_q;
    assign y_out_valid = yv_q;

endmodule

// File: rtl/decim_ctrl.sv
// decim_ctrl: controller for a cascade of NSTAGES hb halfband decimators.
//   cfg_load/cfg_en/cfg_ratio - reconfiguration pulse, enable, log2 ratio
//   x_in/x_in_valid/x_in_ready - Q15 input stream, accepted only in RUN
//   y_out/y_out_valid/y_out_ready - FIFO head behind ready/valid
//   busy     - FLUSH or DRAIN in progress
//   overflow - sticky, a decimated sample was dropped on a full FIFO
//   state    - FSM state for debug
module decim_ctrl
    import decim_pkg::*;
#(
    parameter int unsigned NSTAGES    = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cfg_load,
    input  logic                cfg_en,
    input  logic [1:0]          cfg_ratio,
    input  logic [SAMPLE_W-1:0] x_in,
    input  logic                x_in_valid,
    output logic                x_in_ready,
    output logic [SAMPLE_W-1:0] y_out,
    output logic                y_out_valid,
    input  logic                y_out_ready,
    output logic                busy,
    output logic                overflow,
    output logic [1:0]          state
);

    state_t           state_q, state_d;
    logic [1:0]       ratio_q, ratio_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             overflow_q, overflow_d;
    logic             busy_q, busy_d;
    logic             x_in_ready_q, x_in_ready_d;

    logic [SAMPLE_W-1:0] stg_in_x;
    logic                stg_in_v;
    logic [SAMPLE_W-1:0] st_y  [NSTAGES];
    logic                st_yv [NSTAGES];

    logic [SAMPLE_W-1:0] cand_x;
    logic                cand_v;
    logic                cfg_ok;
    logic                push_req, drop;
    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;

    // Stage-1 feed: zeros during FLUSH, live input in RUN, idle otherwise
    always_comb begin
        stg_in_x = '0;
        stg_in_v = 1'b0;
        case (state_q)
            FLUSH: stg_in_v = 1'b1;
            RUN: begin
                stg_in_x = x_in;
                stg_in_v = x_in_valid;
            end
            default: ;
        endcase
    end

    for (genvar j = 0; j < NSTAGES; j++) begin : g_stage
        if (j == 0) begin : g_first
            hb u_hb (
                .clk        (clk),
                .reset_n    (reset_n),
                .x_in       (stg_in_x),
                .x_in_valid (stg_in_v),
                .y_out      (st_y[j]),
                .y_out_valid(st_yv[j])
            );
        end else begin : g_next
            hb u_hb (
                .clk        (clk),
                .reset_n    (reset_n),
                .x_in       (st_y[j-1]),
                .x_in_valid (st_yv[j-1]),
                .y_out      (st_y[j]),
                .y_out_valid(st_yv[j])
            );
        end
    end

    always_comb begin
        cand_x = x_in;
        cand_v = x_in_valid;
        for (int unsigned i = 1; i <= NSTAGES; i++) begin
            if (32'(ratio_q) == i) begin
                cand_x = st_y[i-1];
                cand_v = st_yv[i-1];
            end
        end
    end

    assign fifo_pop  = !fifo_empty && y_out_ready;
    assign push_req  = (state_q == RUN) && cand_v;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;

    always_comb begin
        state_d     = state_q;
        ratio_d     = ratio_q;
        flush_cnt_d = flush_cnt_q;
        drain_cnt_d = drain_cnt_q;
        overflow_d  = overflow_q | drop;
        cfg_ok      = cfg_en && (32'(cfg_ratio) <= NSTAGES);

        if (cfg_load) begin
            ratio_d    = cfg_ratio;
            overflow_d = 1'b0;
            if (!cfg_ok) begin
                state_d = IDLE;
            end else if (cfg_ratio == 2'd0) begin
                state_d = RUN;
            end else begin
                state_d     = FLUSH;
                flush_cnt_d = flush_len(32'(cfg_ratio));
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    if (flush_cnt_q == CNT_W'(1)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = drain_len(NSTAGES);
                    end
                end
                DRAIN: begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                    if (drain_cnt_q == CNT_W'(1)) begin
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end

        busy_d       = (state_d == FLUSH) || (state_d == DRAIN);
        x_in_ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            ratio_q      <= '0;
            flush_cnt_q  <= '0;
            drain_cnt_q  <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            x_in_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ratio_q      <= ratio_d;
            flush_cnt_q  <= flush_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            x_in_ready_q <= x_in_ready_d;
        end
    end

    decim_fifo #(
        .DEPTH(FIFO_DEPTH),
        .W    (SAMPLE_W)
    ) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (cfg_load),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (cand_x),
        .head   (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign y_out       = fifo_head;
    assign y_out_valid = !fifo_empty;
    assign x_in_ready  = x_in_ready_q;
    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign state       = state_q;

endmodule

// File: tb/tb_decim_ctrl.sv
// tb_decim_ctrl: scoreboard bench for decim_ctrl. Stimulus pushes expected
// samples into a queue; a negedge monitor pops and compares on each handshake.
module tb_decim_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_load = 1'b0;
    logic        cfg_en = 1'b0;
    logic [1:0]  cfg_ratio = 2'd0;
    logic [15:0] x_in = '0;
    logic        x_in_valid = 1'b0;
    logic        x_in_ready;
    logic [15:0] y_out;
    logic        y_out_valid;
    logic        y_out_ready = 1'b0;
    logic        busy;
    logic        overflow;
    logic [1:0]  state;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0;
    int mode = 0;  // 0 exact queue, 1 DC range, 2 must be zero, 3 ignore
    int dc_cnt = 0, zero_cnt = 0, pop_cnt = 0, busy_cnt = 0, pops_before = 0;
    int mv;
    bit busy_seen = 1'b0;

    decim_ctrl #(.NSTAGES(3), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_load   (cfg_load),
        .cfg_en     (cfg_en),
        .cfg_ratio  (cfg_ratio),
        .x_in       (x_in),
        .x_in_valid (x_in_valid),
        .x_in_ready (x_in_ready),
        .y_out      (y_out),
        .y_out_valid(y_out_valid),
        .y_out_ready(y_out_ready),
        .busy       (busy),
        .overflow   (overflow),
        .state      (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt++;
            busy_seen = 1'b1;
        end
        if (y_out_valid && y_out_ready) begin
            pop_cnt++;
            mv = int'($signed(y_out));
            case (mode)
                0: begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %0d, none expected (cycle %0d)", mv, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (y_out !== e.d || (e.c >= 0 && cyc != e.c)) begin
                            errors++;
                            $display("FAIL sample: got %0d at cycle %0d, expected %0d at cycle %0d",
                                     mv, cyc, $signed(e.d), e.c);
                        end
                    end
                end
                1: begin
                    dc_cnt++;
                    if (dc_cnt > 4) begin
                        checks++;
                        if (mv < 998 || mv > 1002) begin
                            errors++;
                            $display("FAIL dc_value: got %0d, expected 1000 +/- 2", mv);
                        end
                    end
                end
                2: begin
                    zero_cnt++;
                    checks++;
                    if (y_out !== 16'd0) begin
                        errors++;
                        $display("FAIL flush_zero: got %0d, expected 0", mv);
                    end
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_cfg(input logic en, input logic [1:0] r);
        cfg_load  = 1'b1;
        cfg_en    = en;
        cfg_ratio = r;
        tick(1);
        cfg_load  = 1'b0;
    endtask

    task automatic feed(input logic [15:0] v, input bit exp, input bit timed);
        x_in       = v;
        x_in_valid = 1'b1;
        if (exp) sb.push_back('{v, timed ? cyc + 1 : -1});
        tick(1);
        x_in_valid = 1'b0;
    endtask

    task automatic wait_ready(input int limit);
        int n = 0;
        while (x_in_ready !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        check("ready_timeout", 32'(x_in_ready), 32'd1);
    endtask

    initial begin
        // reset state
        tick(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(x_in_ready), 32'd0);
        check("rst_valid", 32'(y_out_valid), 32'd0);
        check("rst_yout", 32'(y_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // bypass
        busy_seen   = 1'b0;
        y_out_ready = 1'b1;
        do_cfg(1'b1, 2'd0);
        check("byp_state", 32'(state), 32'd3);
        check("byp_ready", 32'(x_in_ready), 32'd1);
        feed(16'd100, 1'b1, 1'b1);
        feed(-16'sd200, 1'b1, 1'b1);
        feed(16'd300, 1'b1, 1'b1);
        tick(4);
        check("byp_drained", 32'(sb.size()), 32'd0);
        check("byp_busy_seen", 32'(busy_seen), 32'd0);

        // divide-by-2 DC
        mode = 3;
        do_cfg(1'b1, 2'd1);
        busy_cnt = 0;
        check("div2_state", 32'(state), 32'd1);
        check("div2_busy", 32'(busy), 32'd1);
        check("div2_notready", 32'(x_in_ready), 32'd0);
        wait_ready(200);
        check("div2_busy_len", 32'(busy_cnt), 32'd43);
        mode   = 1;
        dc_cnt = 0;
        for (int i = 0; i < 200; i++) feed(16'd1000, 1'b0, 1'b0);
        tick(20);
        checks++;
        if (dc_cnt < 86 || dc_cnt > 114) begin
            errors++;
            $display("FAIL dc_count: got %0d, expected 100 +/- 14", dc_cnt);
        end

        // flush isolation at divide-by-4
        mode = 3;
        do_cfg(1'b1, 2'd2);
        busy_cnt = 0;
        wait_ready(300);
        check("div4_busy_len", 32'(busy_cnt), 32'd99);
        for (int i = 0; i < 500; i++) feed(16'h8000, 1'b0, 1'b0);
        do_cfg(1'b1, 2'd2);
        mode     = 2;
        zero_cnt = 0;
        wait_ready(300);
        for (int i = 0; i < 100; i++) feed(16'd0, 1'b0, 1'b0);
        tick(30);
        checks++;
        if (zero_cnt < 24 || zero_cnt > 26) begin
            errors++;
            $display("FAIL zero_count: got %0d, expected 24..26", zero_cnt);
        end

        // overflow with held consumer
        mode = 0;
        sb.delete();
        y_out_ready = 1'b0;
        do_cfg(1'b1, 2'd0);
        for (int i = 11; i <= 14; i++) feed(16'(i), 1'b1, 1'b0);
        check("ovf_before", 32'(overflow), 32'd0);
        check("ovf_valid", 32'(y_out_valid), 32'd1);
        feed(16'd15, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        feed(16'd16, 1'b0, 1'b0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("ovf_head", 32'(y_out), 32'd11);
        do_cfg(1'b1, 2'd0);
        sb.delete();
        check("ovf_cleared", 32'(overflow), 32'd0);
        check("ovf_fifo_clr", 32'(y_out_valid), 32'd0);

        // full FIFO with simultaneous push and pop
        for (int i = 21; i <= 24; i++) feed(16'(i), 1'b1, 1'b0);
        y_out_ready = 1'b1;
        feed(16'd25, 1'b1, 1'b0);
        y_out_ready = 1'b0;
        check("fullpp_ovf", 32'(overflow), 32'd0);
        check("fullpp_head", 32'(y_out), 32'd22);
        pops_before = pop_cnt;
        y_out_ready = 1'b1;
        tick(8);
        check("fullpp_occ", 32'(pop_cnt - pops_before), 32'd4);
        check("fullpp_drained", 32'(sb.size()), 32'd0);

        // reconfigure mid-FLUSH
        mode = 3;
        do_cfg(1'b1, 2'd3);
        tick(10);
        check("midflush_state", 32'(state), 32'd1);
        do_cfg(1'b1, 2'd1);
        busy_cnt = 0;
        wait_ready(400);
        check("midflush_reload", 32'(busy_cnt), 32'd43);

        // disable
        mode = 0;
        do_cfg(1'b0, 2'd1);
        check("dis_state", 32'(state), 32'd0);
        check("dis_ready", 32'(x_in_ready), 32'd0);
        check("dis_busy", 32'(busy), 32'd0);
        feed(16'd77, 1'b0, 1'b0);
        tick(3);
        check("dis_discard", 32'(y_out_valid), 32'd0);

        // asynchronous reset mid-RUN
        mode        = 3;
        y_out_ready = 1'b0;
        do_cfg(1'b1, 2'd0);
        for (int i = 1; i <= 5; i++) feed(16'(i * 7), 1'b0, 1'b0);
        check("prerst_ovf", 32'(overflow), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_ready", 32'(x_in_ready), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(y_out_valid), 32'd0);
        check("arst_yout", 32'(y_out), 32'd0);
        check("arst_ovf", 32'(overflow), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/decim_ctrl.md
# decim_ctrl

Controller for a cascade of `hb` halfband decimators between the 16-bit audio front end and the downstream processing chain. It does four things:
- selects the decimation ratio (1, 2, 4 or 8);
- flushes stale filter history on every reconfiguration by injecting zeros;
- gates input acceptance;
- buffers decimated samples in a small output FIFO behind a ready/valid handshake, flagging drops.

## Interface
Parameters:
- `NSTAGES`, 3: number of `hb` instances in the cascade; maximum ratio is 2^NSTAGES.
- `FIFO_DEPTH`, 4: output FIFO entries; must be a power of 2 and ≥2.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cfg_load` in 1: one-cycle pulse that applies `cfg_en`/`cfg_ratio`.
- `cfg_en` in 1: enable, sampled on `cfg_load`.
- `cfg_ratio` in 2: log2 of the decimation ratio (0 = bypass, 1 = ÷2, 2 = ÷4, 3 = ÷8), sampled on `cfg_load`; must be ≤ NSTAGES.
- `x_in` in 16: signed Q15 input sample.
- `x_in_valid` in 1: input strobe.
- `x_in_ready` out 1: high only in RUN.
- `y_out` out 16: signed Q15 FIFO head.
- `y_out_valid` out 1: FIFO non-empty.
- `y_out_ready` in 1: consumer accepts the head.
- `busy` out 1: high in FLUSH or DRAIN.
- `overflow` out 1: sticky; a decimated sample was dropped.
- `state` out 2: current FSM state, for debug.

## Operation
- FSM states: IDLE=0, FLUSH=1, DRAIN=2, RUN=3.
- Reset: all outputs 0, state IDLE, FIFO empty, `ratio_q`=0.
- Any `cfg_load` in any state, including mid-FLUSH, mid-DRAIN or mid-RUN:
  - latch `ratio_q`=`cfg_ratio`;
  - clear the FIFO and `overflow`;
  - if `cfg_en`=0, go to IDLE;
  - if `cfg_en`=1 and `cfg_ratio`=0, go directly to RUN;
  - otherwise go to FLUSH and load `flush_cnt`=FLUSH_LEN(`ratio_q`).
  - `cfg_load` with `cfg_ratio` > NSTAGES is treated as `cfg_en`=0.
- Datapath input mux into stage 1:
  - in FLUSH: data 0, valid 1 every cycle;
  - in RUN: `x_in` / `x_in_valid`;
  - otherwise: valid 0.
- Stage j+1 is fed from stage j's `y_out` / `y_out_valid`.
- FLUSH decrements `flush_cnt` once per cycle and moves to DRAIN when `flush_cnt`=1.
- FLUSH_LEN(k) = 28·(2^k − 1), giving 28, 84 and 196 for k = 1, 2 and 3. This clears every delay line up to stage k, including the `hb` one-sample input skew.
- DRAIN waits DRAIN_LEN = 5·NSTAGES cycles, then moves to RUN. Outputs produced in FLUSH and DRAIN are discarded.
- Output select: in RUN, a push candidate is `x_in`/`x_in_valid` when `ratio_q`=0, otherwise the `y_out`/`y_out_valid` of stage `ratio_q`. Stages above `ratio_q` run but are ignored.
- Pushes are only taken in RUN.
- Input arriving outside RUN (`x_in_valid` while `x_in_ready`=0) is discarded silently.
- FIFO behaviour:
  - pop on `y_out_valid`·`y_out_ready`;
  - push when a candidate is present and the FIFO is not full, or is full with a pop in the same cycle;
  - a push while full without a pop drops the sample and sets `overflow`.
- Arithmetic: samples pass through unmodified. No saturation or rescaling is done here.

## Timing
- `cfg_load` at edge n: `state`, `busy` and `x_in_ready` update at edge n+1. Stage-1 injection starts in the cycle after that edge.
- `y_out_valid` falls at n+1 because the FIFO clears.
- Bypass latency: `x_in_valid` at edge n gives `y_out_valid`=1 at n+1 with the FIFO initially empty (registered FIFO, no fall-through).
- Decimated latency: the FIFO adds 1 cycle after the selected stage's `y_out_valid`.
- Total FLUSH+DRAIN cycles for k=2, NSTAGES=3: 84 + 15 = 99.
- An asynchronous reset mid-operation returns everything to the reset state immediately. The `hb` instances share `reset_n`.

## Structure
- Package `decim_pkg`:
  - `state_t` enum (IDLE, FLUSH, DRAIN, RUN);
  - functions `flush_len(k)` and `drain_len(n)`;
  - constant `SAMPLE_W`=16.
- Sub-module `decim_fifo`: parameterised depth, synchronous clear, `push`, `pop`, `full`, `empty`, `head`.
- The NSTAGES `hb` instances are built with a generate loop inside `decim_ctrl`.

## Test plan
- Bypass: after reset, `cfg_load` with en=1, ratio=0, then feed 100, −200, 300 with `y_out_ready`=1 → same three values out, each 1 cycle after input; `busy` never asserted.
- ÷2 DC: load ratio=1 and check `busy` is high for exactly 28+15 cycles. Then feed 200 samples of 1000 → after settling, every output is within ±2 of 1000; output count is 100 ± 14, with the startup transient allowed.
- Flush isolation: run ÷4 on −32768 full-scale for 500 samples, then reload ratio=2 and feed zeros → all outputs after RUN re-entry are exactly 0.
- Overflow: ratio=0, `y_out_ready`=0, feed 6 samples → the FIFO holds the first 4, `overflow`=1 from the 5th push, and the head stays at sample 1. A new `cfg_load` clears `overflow` and empties the FIFO.
- Full with simultaneous pop: FIFO full, push and pop in the same cycle → no drop, `overflow` stays 0, occupancy stays 4.
- Reconfiguration and reset mid-operation:
  - `cfg_load` mid-FLUSH → `flush_cnt` reloads for the new ratio;
  - `cfg_load` with en=0 → IDLE and `x_in_ready`=0;
  - `reset_n` low mid-RUN → all outputs 0 asynchronously.
